// File: rtl/cdc_pkg.sv
// Shared definitions for the multi-channel level synchronizer and its glitch filter.
package cdc_pkg;

  // Width of the per-channel persistence counter. It never drops below 1 bit.
  function automatic int cnt_w(input int filt_cyc);
    int w;
    w = $clog2(filt_cyc + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // What the filter does with its state on the next edge.
  typedef enum logic [1:0] {
    FILT_CLEAR  = 2'd0,
    FILT_COUNT  = 2'd1,
    FILT_ACCEPT = 2'd2
  } filt_act_e;

endpackage

// File: rtl/cdc_glitch_filt.sv
// One-channel persistence filter: a new synchronized level is accepted only
// after it has been seen for FILT_CYC consecutive cycles.
module cdc_glitch_filt
  import cdc_pkg::*;
#(
  parameter int   FILT_CYC = 4,
  parameter logic RST_VAL  = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic s_i,
  output logic filt_o,
  output logic busy_o
);

  localparam int            CW   = cnt_w(FILT_CYC);
  localparam logic [CW-1:0] LAST = CW'(FILT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;
  filt_act_e     act_s;

  always_comb begin
    act_s  = FILT_CLEAR;
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (s_i == filt_q) begin
      act_s = FILT_CLEAR;
    end else if (cnt_q == LAST) begin
      act_s = FILT_ACCEPT;
    end else begin
      act_s = FILT_COUNT;
    end
    case (act_s)
      FILT_CLEAR:  cnt_d = '0;
      FILT_COUNT:  cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      FILT_ACCEPT: begin
        cnt_d  = '0;
        filt_d = s_i;
      end
      default:     cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q  <= '0;
      filt_q <= RST_VAL;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o = filt_q;
  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/cdc_sync_filt.sv
// Multi-channel synchronizer for asynchronous levels: N-flop chain per channel,
// optional glitch filter, and single-cycle rise/fall pulses on the result.
module cdc_sync_filt
  import cdc_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter int               STAGES   = 2,
  parameter int               FILT_CYC = 4,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] i_sig,
  output logic [WIDTH-1:0] o_sig_sync,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall,
  output logic [WIDTH-1:0] o_busy
);

  logic [WIDTH-1:0] s_s;
  logic [WIDTH-1:0] sig_s;
  logic [WIDTH-1:0] busy_s;
  logic [WIDTH-1:0] hist_q;

  // i_sig only ever feeds the first flop; nothing sits between chain flops.
  for (genvar k = 0; k < WIDTH; k++) begin : g_chain
    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
      if (!rstn) begin
        sync_q <= {STAGES{RST_VAL[k]}};
      end else begin
        sync_q <= {sync_q[STAGES-2:0], i_sig[k]};
      end
    end

    assign s_s[k] = sync_q[STAGES-1];
  end

  if (FILT_CYC >= 1) begin : g_filt
    for (genvar k = 0; k < WIDTH; k++) begin : g_ch
      cdc_glitch_filt #(
        .FILT_CYC (FILT_CYC),
        .RST_VAL  (RST_VAL[k])
      ) u_filt (
        .clk    (clk),
        .rstn   (rstn),
        .s_i    (s_s[k]),
        .filt_o (sig_s[k]),
        .busy_o (busy_s[k])
      );
    end
  end else begin : g_bypass
    assign sig_s  = s_s;
    assign busy_s = '0;
  end

  // Resetting hist to RST_VAL suppresses spurious pulses around reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hist_q <= RST_VAL;
    end else begin
      hist_q <= sig_s;
    end
  end

  assign o_sig_sync = sig_s;
  assign o_rise     = sig_s & ~hist_q;
  assign o_fall     = ~sig_s & hist_q;
  assign o_busy     = busy_s;

endmodule
